// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan capture block.
package seg_pkg;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } seg_state_t;

   // Active-high gfedcba patterns, indexed by the nibble they display.
   localparam logic [6:0] SEG_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [2:0] onehot8_to_idx(input logic [7:0] an);
      logic [2:0] idx;
      idx = '0;
      for (int k = 0; k < 8; k++) begin
         if (an[k]) idx = idx | 3'(k);
      end
      return idx;
   endfunction

   function automatic logic isOneHot8(input logic [7:0] an);
      return (an != 8'h00) && ((an & (an - 8'h01)) == 8'h00);
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to nibble decoder; unknown patterns
// (including all segments off) decode to 0 with err set.
module seg7_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] val,
   output logic       err
);

   always_comb begin
      val = 4'h0;
      err = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (pattern == SEG_HEX[k]) begin
            val = 4'(k);
            err = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Rebuilds the eight hex digits shown on a multiplexed seven-segment bus into
// frames and presents each completed frame on a valid/ready port.
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_i,
   input  logic [7:0]  an_i,
   output logic        digit_strobe,
   output logic [2:0]  digit_idx,
   output logic [3:0]  digit_val,
   output logic        digit_err,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic [31:0] frame_digits,
   output logic [7:0]  frame_err,
   output logic        overrun
);

   localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] ACCEPT_AT  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [0:0]       ST_COLLECT = 1'(COLLECT);
   localparam logic [0:0]       ST_HOLD    = 1'(HOLD);

   logic [6:0]       segNorm;
   logic [7:0]       anNorm;
   logic [6:0]       segReg;
   logic [7:0]       anReg;
   logic [CNT_W-1:0] cntReg;
   logic             sameSample;
   logic             anOneHot;
   logic             accept;
   logic [2:0]       acceptIdx;
   logic [7:0]       acceptMask;
   logic [3:0]       decVal;
   logic             decErr;
   logic [7:0]       seenReg;
   logic             completeNow;
   logic [31:0]      nextDigits;
   logic [7:0]       nextErr;
   logic [0:0]       stateReg;

   assign segNorm = ACTIVE_LOW ? ~seg_i : seg_i;
   assign anNorm  = ACTIVE_LOW ? ~an_i  : an_i;

   // The arriving sample is compared with the one already registered, so the
   // counter reaches STABLE_CYCLES on the (STABLE_CYCLES+1)th edge of a hold.
   assign sameSample = ({anNorm, segNorm} == {anReg, segReg});
   assign anOneHot   = isOneHot8(anReg);
   assign accept     = sameSample && anOneHot && (cntReg == ACCEPT_AT);
   assign acceptIdx  = onehot8_to_idx(anReg);
   assign acceptMask = accept ? (8'h01 << acceptIdx) : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         segReg <= '0;
         anReg  <= '0;
         cntReg <= '0;
      end else begin
         segReg <= segNorm;
         anReg  <= anNorm;
         if (!sameSample || !anOneHot) begin
            cntReg <= '0;
         end else if (cntReg != CNT_MAX) begin
            cntReg <= cntReg + CNT_W'(1);
         end
      end
   end

   seg7_pattern_decode u_decode (
      .pattern (segReg),
      .val     (decVal),
      .err     (decErr)
   );

   // Working digit registers; the accepting digit bypasses into the frame view.
   for (genvar gi = 0; gi < 8; gi++) begin : gen_digit
      logic [3:0] valReg;
      logic       errReg;

      always_ff @(posedge clk) begin
         if (rst) begin
            valReg <= '0;
            errReg <= 1'b0;
         end else if (acceptMask[gi]) begin
            valReg <= decVal;
            errReg <= decErr;
         end
      end

      assign nextDigits[4*gi +: 4] = acceptMask[gi] ? decVal : valReg;
      assign nextErr[gi]           = acceptMask[gi] ? decErr : errReg;
   end

   assign completeNow = accept && ((seenReg | acceptMask) == 8'hFF);

   always_ff @(posedge clk) begin
      if (rst) begin
         seenReg <= '0;
      end else if (completeNow) begin
         seenReg <= '0;
      end else begin
         seenReg <= seenReg | acceptMask;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_strobe <= 1'b0;
         digit_idx    <= '0;
         digit_val    <= '0;
         digit_err    <= 1'b0;
      end else begin
         digit_strobe <= accept;
         if (accept) begin
            digit_idx <= acceptIdx;
            digit_val <= decVal;
            digit_err <= decErr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg     <= ST_COLLECT;
         frame_digits <= '0;
         frame_err    <= '0;
         overrun      <= 1'b0;
      end else begin
         overrun <= 1'b0;
         case (stateReg)
            ST_COLLECT: begin
               if (completeNow) begin
                  frame_digits <= nextDigits;
                  frame_err    <= nextErr;
                  stateReg     <= ST_HOLD;
               end
            end
            default: begin
               if (completeNow) begin
                  // A new frame may only replace the held one as it leaves.
                  if (frame_ready) begin
                     frame_digits <= nextDigits;
                     frame_err    <= nextErr;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else if (frame_ready) begin
                  stateReg <= ST_COLLECT;
               end
            end
         endcase
      end
   end

   assign frame_valid = (stateReg == ST_HOLD);

endmodule
